// File: rtl/lc3_pkg.sv
// Shared encodings for the memory access unit: FSM states, fault codes,
// access-size constants and the alignment rule.
package lc3_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic [1:0] FAULT_NONE      = 2'b00;
  localparam logic [1:0] FAULT_UNALIGNED = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT   = 2'b10;

  localparam logic SIZE_BYTE = 1'b0;
  localparam logic SIZE_WORD = 1'b1;

  // A word access to an odd address cannot be issued to memory.
  function automatic logic is_unaligned(input logic size, input logic addr0);
    return (size == SIZE_WORD) && addr0;
  endfunction

endpackage

// File: rtl/byte_lane_mux.sv
// Combinational byte-lane steering: selects and sign-extends the read byte
// for the bus, replicates the store byte onto both lanes and picks the
// byte write enables.
module byte_lane_mux
  import lc3_pkg::*;
(
  input  logic [15:0] mdr_i,
  input  logic        addr0_i,
  input  logic        size_i,
  output logic [15:0] rd_o,
  output logic [15:0] wdata_o,
  output logic [1:0]  we_lanes_o
);

  // Word accesses pass straight through; byte accesses use the lane picked by addr0.
  always_comb begin
    rd_o       = mdr_i;
    wdata_o    = mdr_i;
    we_lanes_o = 2'b11;
    if (size_i == SIZE_BYTE) begin
      wdata_o = {mdr_i[7:0], mdr_i[7:0]};
      if (addr0_i) begin
        rd_o       = {{8{mdr_i[15]}}, mdr_i[15:8]};
        we_lanes_o = 2'b10;
      end else begin
        rd_o       = {{8{mdr_i[7]}}, mdr_i[7:0]};
        we_lanes_o = 2'b01;
      end
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// MAR/MDR memory access unit: issues one byte or word access per start,
// waits for mem_r with a bounded timeout and reports completion with a
// one-cycle done pulse plus a sticky fault code.
module mem_access_unit
  import lc3_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ld_mar,
  input  logic [15:0] mar_in,
  input  logic        ld_mdr,
  input  logic [15:0] mdr_in,
  input  logic        start,
  input  logic        we,
  input  logic        size,
  output logic        mem_en,
  output logic [1:0]  mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_r,
  output logic [15:0] mar,
  output logic [15:0] mdr_bus,
  output logic        busy,
  output logic        done,
  output logic [1:0]  fault
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  state_t           state_q, state_d;
  logic [15:0]      mar_q, mar_d;
  logic [15:0]      mdr_q, mdr_d;
  logic             we_q, we_d;
  logic             size_q, size_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic [1:0]       fault_q, fault_d;
  logic             addr0_eff;
  logic [1:0]       lanes;

  // A start that loads MAR in the same cycle is checked against the incoming address.
  assign addr0_eff = ld_mar ? mar_in[0] : mar_q[0];

  byte_lane_mux u_lanes (
    .mdr_i      (mdr_q),
    .addr0_i    (mar_q[0]),
    .size_i     (size_q),
    .rd_o       (mdr_bus),
    .wdata_o    (mem_wdata),
    .we_lanes_o (lanes)
  );

  // Next-state and request logic; register loads are only honoured outside ACCESS.
  always_comb begin
    state_d = state_q;
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    we_d    = we_q;
    size_d  = size_q;
    wait_d  = wait_q;
    fault_d = fault_q;
    mem_en  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (ld_mar) mar_d = mar_in;
        if (ld_mdr) mdr_d = mdr_in;
        if (start) begin
          we_d   = we;
          size_d = size;
          if (is_unaligned(size, addr0_eff)) begin
            state_d = ST_DONE;
            fault_d = FAULT_UNALIGNED;
          end else begin
            state_d = ST_ACCESS;
            wait_d  = '0;
            fault_d = FAULT_NONE;
          end
        end
      end
      ST_ACCESS: begin
        if (wait_q == TIMEOUT_CNT) begin
          // Request withdrawn on the final cycle; a late mem_r is not accepted.
          state_d = ST_DONE;
          fault_d = FAULT_TIMEOUT;
        end else begin
          mem_en = 1'b1;
          if (mem_r) begin
            state_d = ST_DONE;
            if (!we_q) mdr_d = mem_rdata;
          end else begin
            wait_d = wait_q + CNT_W'(1);
          end
        end
      end
      ST_DONE: begin
        if (ld_mar) mar_d = mar_in;
        if (ld_mdr) mdr_d = mdr_in;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      mar_q   <= '0;
      mdr_q   <= '0;
      we_q    <= 1'b0;
      size_q  <= SIZE_WORD;
      wait_q  <= '0;
      fault_q <= FAULT_NONE;
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      we_q    <= we_d;
      size_q  <= size_d;
      wait_q  <= wait_d;
      fault_q <= fault_d;
    end
  end

  assign mem_we   = (mem_en && we_q) ? lanes : 2'b00;
  assign mem_addr = mar_q;
  assign mar      = mar_q;
  assign busy     = (state_q == ST_ACCESS);
  assign done     = (state_q == ST_DONE);
  assign fault    = fault_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: hand-computed expectations checked
// with immediate assertions, one sample 1 time unit after each rising edge.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        ld_mar;
  logic [15:0] mar_in;
  logic        ld_mdr;
  logic [15:0] mdr_in;
  logic        start;
  logic        we;
  logic        size;
  logic        mem_en;
  logic [1:0]  mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_r;
  logic [15:0] mar;
  logic [15:0] mdr_bus;
  logic        busy;
  logic        done;
  logic [1:0]  fault;

  int compared   = 0;
  int mismatched = 0;
  int acc_cycles = 0;
  int en_cycles  = 0;
  bit seen_done  = 1'b0;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT(15)) dut (
    .clk       (clk),
    .reset     (reset),
    .ld_mar    (ld_mar),
    .mar_in    (mar_in),
    .ld_mdr    (ld_mdr),
    .mdr_in    (mdr_in),
    .start     (start),
    .we        (we),
    .size      (size),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_r     (mem_r),
    .mar       (mar),
    .mdr_bus   (mdr_bus),
    .busy      (busy),
    .done      (done),
    .fault     (fault)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; ld_mar = 1'b0; mar_in = 16'h0; ld_mdr = 1'b0; mdr_in = 16'h0;
    start = 1'b0; we = 1'b0; size = 1'b1; mem_rdata = 16'h0; mem_r = 1'b0;
    tick; tick;
    reset = 1'b0;

    // Reset state
    chk("rst_mar",     32'(mar),     32'h0);
    chk("rst_mdr_bus", 32'(mdr_bus), 32'h0);
    chk("rst_busy",    32'(busy),    32'h0);
    chk("rst_done",    32'(done),    32'h0);
    chk("rst_mem_en",  32'(mem_en),  32'h0);
    chk("rst_fault",   32'(fault),   32'h0);

    // Word read at 0x3000, mem_r after 3 waits, MAR loaded with start
    ld_mar = 1'b1; mar_in = 16'h3000; start = 1'b1; we = 1'b0; size = 1'b1;
    tick;                                   // cycle 1 (ACCESS)
    ld_mar = 1'b0; start = 1'b0;
    chk("rd_busy",     32'(busy),     32'h1);
    chk("rd_mem_en",   32'(mem_en),   32'h1);
    chk("rd_mem_addr", 32'(mem_addr), 32'h3000);
    chk("rd_mem_we",   32'(mem_we),   32'h0);
    ld_mar = 1'b1; mar_in = 16'h5555; ld_mdr = 1'b1; mdr_in = 16'h5555;
    tick;                                   // cycle 2
    ld_mar = 1'b0; ld_mdr = 1'b0;
    chk("busy_mar_hold", 32'(mem_addr), 32'h3000);
    tick;                                   // cycle 3
    tick;                                   // cycle 4: accept
    chk("rd_no_early_done", 32'(done), 32'h0);
    mem_r = 1'b1; mem_rdata = 16'hBEEF;
    tick;                                   // cycle 5
    mem_r = 1'b0; mem_rdata = 16'h0;
    chk("rd_done_c5",  32'(done),    32'h1);
    chk("rd_mdr_bus",  32'(mdr_bus), 32'hBEEF);
    chk("rd_fault",    32'(fault),   32'h0);
    chk("rd_busy_off", 32'(busy),    32'h0);
    tick;
    chk("rd_done_1cyc", 32'(done), 32'h0);

    // Byte read at 0x3001 (high lane), minimum latency
    ld_mar = 1'b1; mar_in = 16'h3001; start = 1'b1; we = 1'b0; size = 1'b0;
    tick;
    ld_mar = 1'b0; start = 1'b0;
    mem_r = 1'b1; mem_rdata = 16'h80FF;
    tick;
    mem_r = 1'b0; mem_rdata = 16'h0;
    chk("brd_done_lat2", 32'(done),    32'h1);
    chk("brd_mdr_bus",   32'(mdr_bus), 32'hFF80);
    tick;

    // Byte write at 0x4001, MDR = 0x1234
    ld_mar = 1'b1; mar_in = 16'h4001; ld_mdr = 1'b1; mdr_in = 16'h1234;
    start = 1'b1; we = 1'b1; size = 1'b0;
    tick;
    ld_mar = 1'b0; ld_mdr = 1'b0; start = 1'b0;
    chk("bwr_wdata", 32'(mem_wdata), 32'h3434);
    chk("bwr_we",    32'(mem_we),    32'h2);
    chk("bwr_en",    32'(mem_en),    32'h1);
    mem_r = 1'b1; mem_rdata = 16'hAAAA;
    tick;
    mem_r = 1'b0;
    chk("bwr_done",    32'(done),    32'h1);
    chk("bwr_mdr_bus", 32'(mdr_bus), 32'h0012);
    tick;

    // Byte write at even address uses the low lane
    ld_mar = 1'b1; mar_in = 16'h4000; start = 1'b1; we = 1'b1; size = 1'b0;
    tick;
    ld_mar = 1'b0; start = 1'b0;
    chk("bwr_lo_we",    32'(mem_we),    32'h1);
    chk("bwr_lo_wdata", 32'(mem_wdata), 32'h3434);
    mem_r = 1'b1;
    tick;
    mem_r = 1'b0;
    tick;

    // Word write at 0x4000
    start = 1'b1; we = 1'b1; size = 1'b1;
    tick;
    start = 1'b0;
    chk("wwr_we",    32'(mem_we),    32'h3);
    chk("wwr_wdata", 32'(mem_wdata), 32'h1234);
    mem_r = 1'b1;
    tick;
    mem_r = 1'b0;
    tick;

    // Unaligned word start at 0x4001
    ld_mar = 1'b1; mar_in = 16'h4001; start = 1'b1; we = 1'b0; size = 1'b1;
    chk("ua_en_pre", 32'(mem_en), 32'h0);
    tick;
    ld_mar = 1'b0; start = 1'b0;
    chk("ua_en",    32'(mem_en), 32'h0);
    chk("ua_busy",  32'(busy),   32'h0);
    chk("ua_done",  32'(done),   32'h1);
    chk("ua_fault", 32'(fault),  32'h1);
    tick;
    chk("ua_done_off",   32'(done),  32'h0);
    chk("ua_fault_held", 32'(fault), 32'h1);

    // Timeout: word read at 0x4000 with mem_r held low
    ld_mar = 1'b1; mar_in = 16'h4000; start = 1'b1; we = 1'b0; size = 1'b1;
    tick;
    ld_mar = 1'b0; start = 1'b0;
    for (int i = 0; i < 40 && !seen_done; i++) begin
      if (done) seen_done = 1'b1;
      else begin
        if (busy) acc_cycles++;
        if (mem_en) en_cycles++;
        tick;
      end
    end
    chk("to_done_seen", 32'(seen_done),  32'h1);
    chk("to_acc_cycles", 32'(acc_cycles), 32'd16);
    chk("to_en_cycles",  32'(en_cycles),  32'd15);
    chk("to_fault",      32'(fault),      32'h2);
    chk("to_mdr_kept",   32'(mdr_bus),    32'h1234);
    start = 1'b1; we = 1'b0; size = 1'b1;   // start in DONE is ignored
    tick;
    start = 1'b0;
    chk("done_start_ign", 32'(busy),  32'h0);
    chk("to_fault_held",  32'(fault), 32'h2);

    // Reset on the second ACCESS cycle
    ld_mar = 1'b1; mar_in = 16'h3000; start = 1'b1; we = 1'b0; size = 1'b1;
    tick;
    ld_mar = 1'b0; start = 1'b0;
    tick;
    chk("mr_busy_c2", 32'(busy), 32'h1);
    reset = 1'b1; mem_r = 1'b1; mem_rdata = 16'hDEAD;
    tick;
    reset = 1'b0; mem_r = 1'b0; mem_rdata = 16'h0;
    chk("mr_mem_en",  32'(mem_en),  32'h0);
    chk("mr_busy",    32'(busy),    32'h0);
    chk("mr_done",    32'(done),    32'h0);
    chk("mr_mar",     32'(mar),     32'h0);
    chk("mr_mdr_bus", 32'(mdr_bus), 32'h0);
    chk("mr_fault",   32'(fault),   32'h0);
    tick;
    chk("mr_no_done", 32'(done), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter TIMEOUT, default 15: maximum cycles spent waiting for mem_r before a timeout fault.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 ld_mar  input  1  load MAR from mar_in; ignored while busy.
REQ-005 mar_in  input  16  effective address from the address adder / MARMUX.
REQ-006 ld_mdr  input  1  load MDR from mdr_in; ignored while busy.
REQ-007 mdr_in  input  16  store data from the bus.
REQ-008 start  input  1  begin an access using the current MAR/MDR; ignored while busy.
REQ-009 we  input  1  sampled with start; 1 = write, 0 = read.
REQ-010 size  input  1  sampled with start; 0 = byte, 1 = word.
REQ-011 mem_en  output  1  memory request, held high until the accepting cycle.
REQ-012 mem_we  output  2  byte write enables {hi, lo}; zero on reads.
REQ-013 mem_addr  output  16  equals MAR.
REQ-014 mem_wdata  output  16  write data.
REQ-015 mem_rdata  input  16  read data, valid when mem_r = 1.
REQ-016 mem_r  input  1  memory ready / accept.
REQ-017 mar  output  16  MAR contents.
REQ-018 mdr_bus  output  16  bus-gated MDR value (see REQ-027).
REQ-019 busy  output  1  high in ACCESS state.
REQ-020 done  output  1  one-cycle completion pulse.
REQ-021 fault  output  2  00 none, 01 unaligned, 10 timeout; valid with done, held until the next start.

Function
REQ-022 States are IDLE, ACCESS, DONE; IDLE->ACCESS on start when aligned; IDLE->DONE on start when unaligned (size = 1 and MAR[0] = 1) with fault = 01 and no memory request.
REQ-023 In ACCESS, mem_en = 1; when mem_r = 1, go to DONE; a read loads MDR from mem_rdata in the same edge.
REQ-024 A wait counter clears on entry to ACCESS and increments each cycle with mem_r = 0; when it reaches TIMEOUT, drop mem_en, go to DONE with fault = 10, MDR unchanged.
REQ-025 DONE lasts exactly one cycle with done = 1, then returns to IDLE; start in DONE is ignored.
REQ-026 Writes: word -> mem_wdata = MDR, mem_we = 11; byte -> mem_wdata = {MDR[7:0], MDR[7:0]}, mem_we = 10 if MAR[0] else 01.
REQ-027 mdr_bus: word -> MDR; byte -> sign-extended MDR[15:8] if MAR[0] = 1 else sign-extended MDR[7:0]; size is the value latched at the last start.
REQ-028 ld_mar and ld_mdr asserted in the same IDLE cycle as start: the registers load on that edge and the access uses the new values from the next cycle; alignment is checked on mar_in in that case.
REQ-029 Read-back latency: minimum 2 cycles from start to done (start edge, accept edge).
REQ-030 MAR, MDR, and the latched we/size never change while busy.

Reset
REQ-031 reset on a clock edge forces IDLE, MAR = 0, MDR = 0, latched size = 1 and we = 0, wait counter = 0, fault = 00.
REQ-032 The same values apply at any time, including mid-access: mem_en, mem_we, busy, and done go low on the following cycle, and no MDR update occurs.

Structure
REQ-033 A shared lc3_pkg holds the state encoding, the fault codes, and the SIZE_BYTE/SIZE_WORD constants.
REQ-034 One sub-module, byte_lane_mux, implements the combinational byte-select, sign-extension, and write-lane replication used by REQ-026 and REQ-027.

Verification
REQ-035 MAR = 0x3000, read word, mem_r after 3 waits with mem_rdata = 0xBEEF -> done at cycle 5, mdr_bus = 0xBEEF, fault = 00.
REQ-036 MAR = 0x3001, byte read, mem_rdata = 0x80FF -> mdr_bus = 0xFF80.
REQ-037 MAR = 0x4001, byte write, MDR = 0x1234 -> mem_wdata = 0x3434, mem_we = 10.
REQ-038 MAR = 0x4001, word start -> mem_en never high, done next cycle, fault = 01.
REQ-039 mem_r held low with TIMEOUT = 15 -> done after 16 cycles in ACCESS, fault = 10, MDR unchanged.
REQ-040 reset asserted on the second ACCESS cycle -> IDLE next cycle, mem_en = 0, MAR = 0, MDR = 0, no done pulse.
